// File: rtl/risc_mem_pkg.sv
// Shared types and defaults for the processor memory responder and its array.
// Contents: default AWIDTH/DWIDTH, FSM state encoding, latched operation type.
// Imported by memory_responder; mem_array is self-contained.
package risc_mem_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array: registered read data, synchronous write.
// Ports: clk, rst (sync, active-high), we/re enables, addr, wdata, rdata.
// Config: MEM_CLEAR_ON_RESET_EN zeroes every word on rst; otherwise plain RAM.
module mem_array #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

`ifdef MEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // No reset term so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end
`endif

  // The read register is the responder's data_out: it resets to zero and
  // holds until the next read is performed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts rd xor wr in IDLE, waits WAIT_STATES cycles, then
// performs the access and pulses ready; rd&wr together in IDLE pulses err.
// Ports: clk, rst, mem_addr, rd, wr, data_in -> data_out, ready, err.
// Config: MEM_CLEAR_ON_RESET_EN (in mem_array) clears memory on rst.
module memory_responder
  import risc_mem_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              ready,
  output logic              err
);

  // Last counter value of the WAIT state; unreachable when WAIT_STATES is 0.
  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

  mem_state_t        state;
  mem_op_t           lat_op;
  logic [2:0]        wait_cnt;
  logic [AWIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0] lat_data;

  logic arr_we;
  logic arr_re;

  // The array access happens on the edge that leaves RESP, so read data and
  // the ready pulse both appear WAIT_STATES+1 edges after acceptance. A
  // reset on that edge suppresses the write, so uncommitted writes are lost.
  assign arr_we = (state == RESP) && (lat_op == OP_WRITE) && !rst;
  assign arr_re = (state == RESP) && (lat_op == OP_READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_op   <= OP_READ;
      wait_cnt <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rd ^ wr) begin
            lat_addr <= mem_addr;
            lat_data <= data_in;
            lat_op   <= wr ? OP_WRITE : OP_READ;
            wait_cnt <= '0;
            state    <= (WAIT_STATES > 0) ? WAIT : RESP;
          end else if (rd && wr) begin
            err <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == WS_LAST) begin
            wait_cnt <= '0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RESP: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .addr (lat_addr),
    .wdata(lat_data),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  logic       clk;
  logic       rst_s  [3];
  logic       rd_s   [3];
  logic       wr_s   [3];
  logic [4:0] addr_s [3];
  logic [7:0] din_s  [3];
  logic [7:0] dout_s [3];
  logic       rdy_s  [3];
  logic       err_s  [3];

  int n_assert;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  memory_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst_s[0]), .mem_addr(addr_s[0]), .rd(rd_s[0]), .wr(wr_s[0]),
    .data_in(din_s[0]), .data_out(dout_s[0]), .ready(rdy_s[0]), .err(err_s[0]));

  memory_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst_s[1]), .mem_addr(addr_s[1]), .rd(rd_s[1]), .wr(wr_s[1]),
    .data_in(din_s[1]), .data_out(dout_s[1]), .ready(rdy_s[1]), .err(err_s[1]));

  memory_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst_s[2]), .mem_addr(addr_s[2]), .rd(rd_s[2]), .wr(wr_s[2]),
    .data_in(din_s[2]), .data_out(dout_s[2]), .ready(rdy_s[2]), .err(err_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on instance i with wait states ws. After acceptance the
  // address is flipped by 0x17 and data inverted to show they are ignored.
  task automatic do_op(input int i, input int ws, input bit is_wr,
                       input logic [4:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input string tag);
    step();
    rd_s[i]   = !is_wr;
    wr_s[i]   = is_wr;
    addr_s[i] = a;
    din_s[i]  = d;
    step();
    rd_s[i]   = 1'b0;
    wr_s[i]   = 1'b0;
    addr_s[i] = a ^ 5'h17;
    din_s[i]  = ~d;
    chk({tag, " rdy@k"}, 32'(rdy_s[i]), 32'd0);
    for (int j = 1; j <= ws; j++) begin
      step();
      chk($sformatf("%s rdy@k+%0d", tag, j), 32'(rdy_s[i]), 32'd0);
    end
    step();
    chk({tag, " rdy pulse"}, 32'(rdy_s[i]), 32'd1);
    if (!is_wr) chk({tag, " rdata"}, 32'(dout_s[i]), 32'(exp_rd));
    step();
    chk({tag, " rdy end"}, 32'(rdy_s[i]), 32'd0);
    if (!is_wr) chk({tag, " rdata hold"}, 32'(dout_s[i]), 32'(exp_rd));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      rst_s[i]  = 1'b1;
      rd_s[i]   = 1'b0;
      wr_s[i]   = 1'b0;
      addr_s[i] = '0;
      din_s[i]  = '0;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst dout%0d", i), 32'(dout_s[i]), 32'd0);
      chk($sformatf("rst rdy%0d", i), 32'(rdy_s[i]), 32'd0);
      chk($sformatf("rst err%0d", i), 32'(err_s[i]), 32'd0);
      rst_s[i] = 1'b0;
    end
    step();

    // WAIT_STATES=0: write A5 to 0A then read it back.
    do_op(0, 0, 1'b1, 5'h0A, 8'hA5, 8'h00, "ws0 wr0A");
    do_op(0, 0, 1'b0, 5'h0A, 8'h00, 8'hA5, "ws0 rd0A");

    // WAIT_STATES=3: decoy at 03, write 3C to 14, read 14 (addr -> 03 in WAIT).
    do_op(2, 3, 1'b1, 5'h03, 8'h77, 8'h00, "ws3 wr03");
    do_op(2, 3, 1'b1, 5'h14, 8'h3C, 8'h00, "ws3 wr14");
    do_op(2, 3, 1'b0, 5'h14, 8'h00, 8'h3C, "ws3 rd14");

    // Conflicting strobes in IDLE: err pulse, no access.
    do_op(0, 0, 1'b1, 5'h1F, 8'h5A, 8'h00, "ws0 wr1F");
    step();
    rd_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 5'h1F; din_s[0] = 8'hFF;
    step();
    rd_s[0] = 1'b0; wr_s[0] = 1'b0;
    chk("both err", 32'(err_s[0]), 32'd1);
    chk("both rdy", 32'(rdy_s[0]), 32'd0);
    step();
    chk("both err end", 32'(err_s[0]), 32'd0);
    chk("both rdy2", 32'(rdy_s[0]), 32'd0);
    do_op(0, 0, 1'b0, 5'h1F, 8'h00, 8'h5A, "ws0 rd1F");

    // WAIT_STATES=2: reset during WAIT of a write to 03.
    do_op(1, 2, 1'b1, 5'h03, 8'h66, 8'h00, "ws2 wr03");
    do_op(1, 2, 1'b0, 5'h03, 8'h00, 8'h66, "ws2 rd03");
    step();
    wr_s[1] = 1'b1; addr_s[1] = 5'h03; din_s[1] = 8'h99;
    step();
    wr_s[1] = 1'b0;
    step();
    rst_s[1] = 1'b1;
    step();
    rst_s[1] = 1'b0;
    chk("midrst rdy", 32'(rdy_s[1]), 32'd0);
    chk("midrst dout", 32'(dout_s[1]), 32'd0);
    chk("midrst err", 32'(err_s[1]), 32'd0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("midrst no rdy %0d", j), 32'(rdy_s[1]), 32'd0);
    end
`ifdef MEM_CLEAR_ON_RESET_EN
    do_op(1, 2, 1'b0, 5'h03, 8'h00, 8'h00, "ws2 rd03 post-rst");
`else
    do_op(1, 2, 1'b0, 5'h03, 8'h00, 8'h66, "ws2 rd03 post-rst");
`endif

    // Back-to-back: write 11 to 00, rd held from the write's RESP cycle.
    step();
    wr_s[0] = 1'b1; addr_s[0] = 5'h00; din_s[0] = 8'h11;
    step();
    wr_s[0] = 1'b0; rd_s[0] = 1'b1;
    step();
    chk("b2b wr rdy", 32'(rdy_s[0]), 32'd1);
    chk("b2b dout keep", 32'(dout_s[0]), 32'h5A);
    step();
    chk("b2b gap", 32'(rdy_s[0]), 32'd0);
    step();
    chk("b2b rd rdy", 32'(rdy_s[0]), 32'd1);
    chk("b2b rd data", 32'(dout_s[0]), 32'h11);
    rd_s[0] = 1'b0;
    step();
    chk("b2b rd rdy end", 32'(rdy_s[0]), 32'd0);
    step();
    chk("b2b single rd", 32'(rdy_s[0]), 32'd0);

    // Fill every word with address+1, reset, read the top word.
    for (int a = 0; a < 32; a++) begin
      do_op(0, 0, 1'b1, 5'(a), 8'(a + 1), 8'h00, $sformatf("fill%0d", a));
    end
    step();
    rst_s[0] = 1'b1;
    step();
    rst_s[0] = 1'b0;
    chk("fill rst dout", 32'(dout_s[0]), 32'd0);
`ifdef MEM_CLEAR_ON_RESET_EN
    do_op(0, 0, 1'b0, 5'h1F, 8'h00, 8'h00, "fill rd1F");
`else
    do_op(0, 0, 1'b0, 5'h1F, 8'h00, 8'h20, "fill rd1F");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
